// File: rtl/clk_div.sv
// ============================================================================
//  Module   : clk_div
//  Purpose  : Terminal-count divider producing a one-clk-wide enable strobe
//             every N clk cycles. Defining CLK_DIV_SIM_FAST_EN swaps the
//             ratio to SIM_DIV for short simulations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div #(
  parameter int DIV_COUNT = 12_500_000,
  parameter int CNT_W     = 24,
  parameter int SIM_DIV   = 4
) (
  input  logic clk,
  input  logic rst,
  output logic clk_en
);

`ifdef CLK_DIV_SIM_FAST_EN
  localparam bit c_fast = 1'b1;
`else
  localparam bit c_fast = 1'b0;
`endif

  localparam int     c_n       = c_fast ? SIM_DIV : DIV_COUNT;
  localparam longint c_n_l     = longint'(c_n);
  localparam longint c_cnt_max = (CNT_W >= 63) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                               : ((64'sd1 <<< CNT_W) - 64'sd1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(c_n - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  // Reject ratios that cannot be represented before anything is built.
  if (c_n < 1) begin : g_bad_ratio
    $error("clk_div: divide ratio %0d must be at least 1", c_n);
  end

  if (c_n_l - 64'sd1 > c_cnt_max) begin : g_bad_width
    $error("clk_div: ratio %0d needs more than CNT_W=%0d counter bits", c_n, CNT_W);
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_en;
  logic             w_wrap;

  assign w_wrap = (r_cnt == c_last);

  // Compare-and-clear wrap keeps the counter inside 0..N-1 for any CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_one;
      end
      r_clk_en <= w_wrap;
    end
  end

  assign clk_en = r_clk_en;

endmodule

`default_nettype wire

// File: tb/tb_clk_div.sv
// ============================================================================
//  Module   : tb_clk_div
//  Purpose  : Self-checking bench for clk_div (ratios 5, 1 and 3 side by side).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div;

`ifdef CLK_DIV_SIM_FAST_EN
  localparam int N5 = 4;
  localparam int N1 = 4;
  localparam int N3 = 4;
`else
  localparam int N5 = 5;
  localparam int N1 = 1;
  localparam int N3 = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en5, en1, en3;

  always #5 clk = ~clk;

  clk_div #(.DIV_COUNT(5), .CNT_W(24), .SIM_DIV(4)) u_dut5 (.clk(clk), .rst(rst), .clk_en(en5));
  clk_div #(.DIV_COUNT(1), .CNT_W(24), .SIM_DIV(4)) u_dut1 (.clk(clk), .rst(rst), .clk_en(en1));
  clk_div #(.DIV_COUNT(3), .CNT_W(24), .SIM_DIV(4)) u_dut3 (.clk(clk), .rst(rst), .clk_en(en3));

  int tests = 0;
  int fails = 0;
  int k     = 0;   // rising edges seen since reset was last released
  bit valid = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else      k <= k + 1;
  end

  // After edge k the strobe is high exactly when k is a non-zero multiple of N.
  function automatic logic exp_en(input int edges, input int n);
    return (edges >= 1) && ((edges % n) == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      check("model_en5", {31'd0, en5}, {31'd0, exp_en(k, N5)});
      check("model_en1", {31'd0, en1}, {31'd0, exp_en(k, N1)});
      check("model_en3", {31'd0, en3}, {31'd0, exp_en(k, N3)});
      check("model_cnt5", {8'd0, u_dut5.r_cnt}, 32'(k % N5));
      check("model_cnt1", {8'd0, u_dut1.r_cnt}, 32'(k % N1));
    end
  end

  int pulses5;
  int highs1;
  int first;
  bit seen;
`ifndef CLK_DIV_SIM_FAST_EN
  logic [9:0] pat5;
`endif

  initial begin
    rst = 1'b0;
    #98;
    check("rst_en5", {31'd0, en5}, 32'd0);
    check("rst_en1", {31'd0, en1}, 32'd0);
    check("rst_cnt5", {8'd0, u_dut5.r_cnt}, 32'd0);
    valid = 1'b1;
    #4 rst = 1'b1;

`ifndef CLK_DIV_SIM_FAST_EN
    // Hand-derived: low on edges 1-4, high after edge 5, low 6-9, high after 10.
    pat5 = 10'b10_0001_0000;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      check("lit_en5_edge", {31'd0, en5}, {31'd0, pat5[e-1]});
      check("lit_en1_edge", {31'd0, en1}, 32'd1);
    end
`else
    repeat (2 * N5) @(posedge clk);
`endif

    pulses5 = 0;
    highs1  = 0;
    for (int e = 0; e < 100 * N5; e++) begin
      @(posedge clk); #1;
      if (en5) pulses5++;
      if (en1) highs1++;
    end
    check("lit_pulses5", 32'(pulses5), 32'd100);
`ifndef CLK_DIV_SIM_FAST_EN
    check("lit_highs1", 32'(highs1), 32'd500);
`endif

    // Asynchronous reset while the strobe is high.
    seen = 1'b0;
    for (int e = 0; e < 2 * N5 && !seen; e++) begin
      @(posedge clk); #1;
      if (en5) seen = 1'b1;
    end
    check("wait_en5_high", {31'd0, seen}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_en5", {31'd0, en5}, 32'd0);
    check("async_en1", {31'd0, en1}, 32'd0);
    check("async_cnt5", {8'd0, u_dut5.r_cnt}, 32'd0);
    check("async_no_edge", {31'd0, clk}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;

    first = 0;
    for (int e = 1; e <= N5 + 3 && first == 0; e++) begin
      @(posedge clk); #1;
      if (en5) first = e;
    end
`ifndef CLK_DIV_SIM_FAST_EN
    check("lit_first_after_rst", 32'(first), 32'd5);
`else
    check("lit_first_after_rst", 32'(first), 32'd4);
`endif

    repeat (3 * N5) @(posedge clk);
    @(negedge clk); #1;
    valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
